// File: rtl/pow_5_arb_pkg.sv
// Shared types and helpers for the pow_5 round-robin arbiter: default sizes,
// the requester tag carried alongside each operand, and round-robin stepping.
package pow_5_arb_pkg;

    localparam int ARB_W   = 8;
    localparam int ARB_N   = 4;
    localparam int ARB_LAT = 1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ARB_IDW = id_width(ARB_N);

    // Tag for the default configuration; the arbiter builds the same shape at its own N.
    typedef struct packed {
        logic               vld;
        logic [ARB_IDW-1:0] id;
    } tag_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pow_5_tag_pipe.sv
// LAT-deep shift register of {valid, id} tags that tracks operands through the
// pow_5 datapath so each result can be matched to its requester.
module pow_5_tag_pipe
    import pow_5_arb_pkg::*;
#(
    parameter int TAG_W = ARB_IDW + 1,
    parameter int LAT   = ARB_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] i_tag,
    output logic [TAG_W-1:0] o_tag
);

    logic [TAG_W-1:0] r_stage [LAT];

    // NOTE: every stage is reset, not just the head; a stale valid bit left in
    // the pipe would emit a phantom result after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[LAT-1];

endmodule

// File: rtl/pow_5_rr_arbiter.sv
// Round-robin arbiter sharing one fifth-power datapath among N requesters.
// Define POW_5_ARB_CHECK_EN to gate results on dp_res_vld and flag tag mismatches on err.
module pow_5_rr_arbiter
    import pow_5_arb_pkg::*;
#(
    parameter int  W   = ARB_W,
    parameter int  N   = ARB_N,
    parameter int  LAT = ARB_LAT,
    localparam int IDW = id_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_vld,
    input  logic [N*W-1:0]   req_n,
    output logic [N-1:0]     req_rdy,
    output logic             dp_n_vld,
    output logic [W-1:0]     dp_n,
    input  logic             dp_res_vld,
    input  logic [W-1:0]     dp_res,
    output logic             res_vld,
    output logic [IDW-1:0]   res_id,
    output logic [W-1:0]     res,
    output logic             err
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } arb_tag_t;

    logic [IDW-1:0] r_ptr;
    logic           r_dp_n_vld;
    logic [W-1:0]   r_dp_n;
    arb_tag_t       r_tag_in;
    arb_tag_t       w_tag_out;
    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_gnt_id;
    logic           w_hs;
    logic           w_res_fire;
    logic           r_res_vld;
    logic [IDW-1:0] r_res_id;
    logic [W-1:0]   r_res;

    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        int idx;
        w_gnt    = '0;
        w_gnt_id = '0;
        idx      = int'(r_ptr);
        for (int k = 0; k < N; k++) begin
            idx = rr_next(idx, N);
            if (rst_n && (w_gnt == '0) && req_vld[idx]) begin
                w_gnt[idx] = 1'b1;
                w_gnt_id   = IDW'(idx);
            end
        end
    end

    assign w_hs    = |w_gnt;
    assign req_rdy = w_gnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= IDW'(N - 1);
            r_dp_n_vld <= 1'b0;
            r_dp_n     <= '0;
            r_tag_in   <= '0;
        end else begin
            r_dp_n_vld   <= w_hs;
            r_tag_in.vld <= w_hs;
            if (w_hs) begin
                r_ptr       <= w_gnt_id;
                r_dp_n      <= req_n[int'(w_gnt_id)*W +: W];
                r_tag_in.id <= w_gnt_id;
            end
        end
    end

    assign dp_n_vld = r_dp_n_vld;
    assign dp_n     = r_dp_n;

    pow_5_tag_pipe #(
        .TAG_W (IDW + 1),
        .LAT   (LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (r_tag_in),
        .o_tag (w_tag_out)
    );

`ifdef POW_5_ARB_CHECK_EN
    logic r_err;

    assign w_res_fire = w_tag_out.vld & dp_res_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_tag_out.vld != dp_res_vld) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_dp_res_vld;

    assign w_res_fire          = w_tag_out.vld;
    assign w_unused_dp_res_vld = dp_res_vld;
    assign err                 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_vld <= 1'b0;
            r_res_id  <= '0;
            r_res     <= '0;
        end else begin
            r_res_vld <= w_res_fire;
            if (w_res_fire) begin
                r_res_id <= w_tag_out.id;
                r_res    <= dp_res;
            end
        end
    end

    assign res_vld = r_res_vld;
    assign res_id  = r_res_id;
    assign res     = r_res;

endmodule

// File: tb/tb_pow_5_rr_arbiter.sv
// Directed bench for pow_5_rr_arbiter (W=8, N=4) with a one-cycle fifth-power
// datapath model; expected grants and results are written out by hand.
module tb_pow_5_rr_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 1;

`ifdef POW_5_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_n;
    logic [N-1:0]   req_rdy;
    logic           dp_n_vld;
    logic [W-1:0]   dp_n;
    logic           dp_res_vld;
    logic [W-1:0]   dp_res;
    logic           res_vld;
    logic [1:0]     res_id;
    logic [W-1:0]   res;
    logic           err;

    logic           m_vld;
    logic [W-1:0]   m_res;
    logic           force_vld;

    int n_total = 0;
    int n_pass  = 0;

    logic       d_v   [3];
    int         d_id  [3];
    logic [7:0] d_res [3];

    always #5 clk = ~clk;

    pow_5_rr_arbiter #(
        .W   (W),
        .N   (N),
        .LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_n      (req_n),
        .req_rdy    (req_rdy),
        .dp_n_vld   (dp_n_vld),
        .dp_n       (dp_n),
        .dp_res_vld (dp_res_vld),
        .dp_res     (dp_res),
        .res_vld    (res_vld),
        .res_id     (res_id),
        .res        (res),
        .err        (err)
    );

    function automatic logic [7:0] pow5(input logic [7:0] x);
        logic [7:0] r;
        r = 8'd1;
        for (int i = 0; i < 5; i++) r = r * x;
        return r;
    endfunction

    // One-cycle fifth-power datapath sharing rst_n with the arbiter.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_res <= '0;
        end else begin
            m_vld <= dp_n_vld;
            m_res <= pow5(dp_n);
        end
    end

    assign dp_res_vld = m_vld | force_vld;
    assign dp_res     = m_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_line();
        for (int i = 0; i < 3; i++) begin
            d_v[i]   = 1'b0;
            d_id[i]  = 0;
            d_res[i] = '0;
        end
    endtask

    // One clock: drive req_vld, check the grant, clock, then check issue and the
    // result owed by the handshake two cycles earlier.
    task automatic cycle(input logic [3:0] vld, input logic [3:0] exp_rdy, input logic [7:0] exp_res);
        int id;
        id = 0;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
        req_vld = vld;
        #1;
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            d_v[i]   = d_v[i-1];
            d_id[i]  = d_id[i-1];
            d_res[i] = d_res[i-1];
        end
        d_v[0]   = (exp_rdy != 4'b0000);
        d_id[0]  = id;
        d_res[0] = exp_res;
        check("dp_n_vld", 32'(dp_n_vld), 32'(d_v[0]));
        if (d_v[0]) check("dp_n", 32'(dp_n), 32'(req_n[id*W +: W]));
        check("res_vld", 32'(res_vld), 32'(d_v[2]));
        if (d_v[2]) begin
            check("res_id", 32'(res_id), 32'(d_id[2]));
            check("res", 32'(res), 32'(d_res[2]));
        end
        check("err_idle", 32'(err), 32'd0);
    endtask

    initial begin
        clear_line();
        force_vld = 1'b0;
        rst_n     = 1'b0;
        req_vld   = 4'b1111;
        req_n     = {8'd2, 8'd255, 8'd4, 8'd3};

        // Reset wins over simultaneous requests.
        #1;
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_dp_n_vld", 32'(dp_n_vld), 32'd0);
        check("rst_dp_n", 32'(dp_n), 32'd0);
        check("rst_res_vld", 32'(res_vld), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        req_vld = 4'b0000;
        rst_n   = 1'b1;

        // Single requests: 3^5=243, 4^5 wraps to 0, 255^5=255, 2^5=32.
        cycle(4'b0001, 4'b0001, 8'd243);
        cycle(4'b0000, 4'b0000, 8'd0);
        cycle(4'b0000, 4'b0000, 8'd0);
        cycle(4'b0010, 4'b0010, 8'd0);
        cycle(4'b0100, 4'b0100, 8'd255);
        cycle(4'b1000, 4'b1000, 8'd32);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 8'd0);

        // All four requesting, n_i = i+1.
        req_n = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int r = 0; r < 2; r++) begin
            cycle(4'b1111, 4'b0001, 8'd1);
            cycle(4'b1111, 4'b0010, 8'd32);
            cycle(4'b1111, 4'b0100, 8'd243);
            cycle(4'b1111, 4'b1000, 8'd0);
        end
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 8'd0);

        // Sparse: bring ptr to 1, then 1 and 3 alternate; late requester 0 cuts in.
        cycle(4'b0010, 4'b0010, 8'd32);
        cycle(4'b1010, 4'b1000, 8'd0);
        cycle(4'b1010, 4'b0010, 8'd32);
        cycle(4'b1010, 4'b1000, 8'd0);
        cycle(4'b1011, 4'b0001, 8'd1);
        cycle(4'b1010, 4'b0010, 8'd32);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 8'd0);

        // Reset with operations in flight.
        cycle(4'b0100, 4'b0100, 8'd243);
        cycle(4'b1000, 4'b1000, 8'd0);
        cycle(4'b0010, 4'b0010, 8'd32);
        rst_n   = 1'b0;
        req_vld = 4'b1111;
        #1;
        check("midrst_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        clear_line();
        check("midrst_res_vld", 32'(res_vld), 32'd0);
        check("midrst_dp_n_vld", 32'(dp_n_vld), 32'd0);
        check("midrst_res", 32'(res), 32'd0);
        check("midrst_res_id", 32'(res_id), 32'd0);
        rst_n = 1'b1;
        cycle(4'b1111, 4'b0001, 8'd1);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 8'd0);

        // Datapath valid with no tag in flight.
        force_vld = 1'b1;
        @(posedge clk); #1;
        force_vld = 1'b0;
        check("err_set", 32'(err), 32'(EXP_ERR));
        check("err_res_vld", 32'(res_vld), 32'd0);
        @(posedge clk); #1;
        check("err_sticky", 32'(err), 32'(EXP_ERR));
        @(posedge clk); #1;
        check("err_sticky2", 32'(err), 32'(EXP_ERR));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("err_cleared", 32'(err), 32'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
